// File: rtl/barcode_reader.sv
// -----------------------------------------------------------------------------
// barcode_reader
//   Receive end of the station barcode link. Decodes the pulse-width coded
//   serial BC line into an 8-bit station ID for the navigation control.
//
//   Line code: every cell begins with a falling edge of BC. The start cell is
//   low for P/2. That low time is measured and stored as dur. Each of the 8
//   data cells (MSB first) is then sampled dur clocks after its falling edge:
//   a '1' (low P/4) reads high there, and a '0' (low 3P/4) reads low.
//
//   Handshake: ID_vld rises for one new, valid ID and stays high until the
//   consumer pulses clr_ID_vld, or until a new start bit arrives. If a new ID
//   is set in the same cycle as clr_ID_vld, the set wins. ID holds its value
//   between valid frames.
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  asynchronous, active-high reset
//   BC          in   1  raw serial barcode line, idles high, asynchronous
//   clr_ID_vld  in   1  consumer has read ID; drop ID_vld
//   ID          out  8  last valid station ID
//   ID_vld      out  1  ID holds a valid, unconsumed station ID
//   busy        out  1  a frame is being decoded (state != IDLE)
// -----------------------------------------------------------------------------
module barcode_reader #(
    parameter int CNT_W   = 22,
    parameter int MIN_LOW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_FALL = 3'd2,
        SAMPLE    = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state, state_nxt;
    logic             bc_q1, bc_q2, bc_q3;
    logic             bc_s, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] dur, dur_nxt;
    logic [7:0]       shft, shft_nxt;
    logic [3:0]       bitcnt, bitcnt_nxt;
    logic             cnt_max;
    logic             clear_vld;
    logic             frame_end;
    logic             set_vld;

    // Two flops resynchronise BC, and the third flop holds the previous
    // synchronised level for edge detection. All three reset to 1 (idle
    // line), so a fall cannot be seen just because reset was released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_q1 <= 1'b1;
            bc_q2 <= 1'b1;
            bc_q3 <= 1'b1;
        end else begin
            bc_q1 <= BC;
            bc_q2 <= bc_q1;
            bc_q3 <= bc_q2;
        end
    end

    assign bc_s      = bc_q2;
    assign fall      = bc_q3 & ~bc_q2;
    assign cnt_max   = &cnt;
    assign busy      = (state != IDLE);
    assign frame_end = (state == DONE);
    // Frames whose two MSBs are not 00 are out of the station ID range.
    assign set_vld   = frame_end && (shft[7:6] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dur    <= '0;
            shft   <= '0;
            bitcnt <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dur    <= dur_nxt;
            shft   <= shft_nxt;
            bitcnt <= bitcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dur_nxt    = dur;
        shft_nxt   = shft;
        bitcnt_nxt = bitcnt;
        clear_vld  = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_nxt   = '0;
                    clear_vld = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bc_s) begin
                    if (cnt < MIN_LOW_C) begin
                        state_nxt = IDLE;
                    end else begin
                        dur_nxt    = cnt;
                        bitcnt_nxt = '0;
                        state_nxt  = WAIT_FALL;
                    end
                end else if (cnt_max) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    cnt_nxt   = '0;
                    state_nxt = SAMPLE;
                end else if (cnt_max) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end
            SAMPLE: begin
                // Falls before the sample point are ignored. Only the sample
                // point decides the bit.
                if (cnt == dur) begin
                    shft_nxt   = {shft[6:0], bc_s};
                    bitcnt_nxt = bitcnt + 4'd1;
                    cnt_nxt    = '0;
                    state_nxt  = (bitcnt == 4'd7) ? DONE : WAIT_FALL;
                end else if (cnt_max) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID     <= 8'h00;
            ID_vld <= 1'b0;
        end else begin
            if (set_vld) begin
                ID <= shft;
            end
            if (set_vld) begin
                ID_vld <= 1'b1;
            end else if (clr_ID_vld || clear_vld) begin
                ID_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_barcode_reader.sv
// -----------------------------------------------------------------------------
// tb_barcode_reader
//   Directed bench for barcode_reader. It uses a short cell period P = 256
//   clocks and CNT_W = 10, so that line timeouts take about 1k clocks.
//   Stimulus is driven on negedge, and checks are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_barcode_reader;

    localparam int P     = 256;
    localparam int CNT_W = 10;

    logic       clk;
    logic       rst;
    logic       BC;
    logic       clr_ID_vld;
    logic [7:0] ID;
    logic       ID_vld;
    logic       busy;

    int total = 0;
    int bad   = 0;

    barcode_reader #(.CNT_W(CNT_W), .MIN_LOW(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .BC         (BC),
        .clr_ID_vld (clr_ID_vld),
        .ID         (ID),
        .ID_vld     (ID_vld),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic send_cell(input int low);
        BC = 1'b0;
        repeat (low) @(negedge clk);
        BC = 1'b1;
        repeat (P - low) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        BC = 1'b0;
        repeat (P / 2) @(negedge clk);
        check("busy_in_frame", {31'b0, busy}, 32'd1);
        check("vld_cleared_by_start", {31'b0, ID_vld}, 32'd0);
        BC = 1'b1;
        repeat (P / 2) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            send_cell(b[i] ? (P / 4) : (3 * P / 4));
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        rst        = 1'b1;
        BC         = 1'b1;
        clr_ID_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_id", {24'b0, ID}, 32'h00);
        check("rst_vld", {31'b0, ID_vld}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single frame 0x01
        send_byte(8'h01);
        check("t1_id", {24'b0, ID}, 32'h01);
        check("t1_vld", {31'b0, ID_vld}, 32'd1);
        check("t1_busy_after", {31'b0, busy}, 32'd0);

        // 2: back-to-back 0x02, 0x25
        send_byte(8'h02);
        check("t2_id_a", {24'b0, ID}, 32'h02);
        check("t2_vld_a", {31'b0, ID_vld}, 32'd1);
        check("t2_dur_range", {31'b0, (dut.dur >= 10'd126) && (dut.dur <= 10'd130)}, 32'd1);
        send_byte(8'h25);
        check("t2_id_b", {24'b0, ID}, 32'h25);
        check("t2_vld_b", {31'b0, ID_vld}, 32'd1);

        // 3: out-of-range ID is discarded
        send_byte(8'hC3);
        check("t3_id_kept", {24'b0, ID}, 32'h25);
        check("t3_vld", {31'b0, ID_vld}, 32'd0);
        check("t3_busy_after", {31'b0, busy}, 32'd0);

        // 4: clr_ID_vld in the same cycle as DONE, so the set wins
        seen = 1'b0;
        fork
            send_byte(8'h11);
            begin
                n = 0;
                while (!dut.frame_end && n < 4 * P * 10) begin
                    @(negedge clk);
                    n++;
                end
                if (dut.frame_end) begin
                    seen       = 1'b1;
                    clr_ID_vld = 1'b1;
                    @(negedge clk);
                    clr_ID_vld = 1'b0;
                end
            end
        join
        check("t4_done_seen", {31'b0, seen}, 32'd1);
        check("t4_id", {24'b0, ID}, 32'h11);
        check("t4_vld_set_wins", {31'b0, ID_vld}, 32'd1);
        repeat (5) @(negedge clk);
        clr_ID_vld = 1'b1;
        @(negedge clk);
        clr_ID_vld = 1'b0;
        check("t4_vld_cleared", {31'b0, ID_vld}, 32'd0);
        check("t4_id_held", {24'b0, ID}, 32'h11);

        // 5a: short low pulse is rejected as a glitch
        BC = 1'b0;
        repeat (8) @(negedge clk);
        BC = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_glitch_busy", {31'b0, busy}, 32'd0);
        check("t5_glitch_vld", {31'b0, ID_vld}, 32'd0);
        check("t5_glitch_id", {24'b0, ID}, 32'h11);

        // 5b: start bit followed by a line stuck high times out
        BC = 1'b0;
        repeat (P / 2) @(negedge clk);
        BC = 1'b1;
        repeat (P / 2) @(negedge clk);
        check("t5_stuck_busy_mid", {31'b0, busy}, 32'd1);
        n = 0;
        while (busy && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout_idle", {31'b0, busy}, 32'd0);
        check("t5_timeout_vld", {31'b0, ID_vld}, 32'd0);
        check("t5_timeout_id", {24'b0, ID}, 32'h11);

        // 6: reset mid-frame after the 4th bit, then decode a full frame
        send_byte(8'h05);
        check("t6_pre_id", {24'b0, ID}, 32'h05);
        send_cell(P / 2);
        send_cell(3 * P / 4);
        send_cell(P / 4);
        send_cell(P / 4);
        send_cell(3 * P / 4);
        check("t6_busy_before_rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_id", {24'b0, ID}, 32'h00);
        check("t6_rst_vld", {31'b0, ID_vld}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_idle_after_rst", {31'b0, busy}, 32'd0);
        send_byte(8'h3F);
        check("t6_id", {24'b0, ID}, 32'h3F);
        check("t6_vld", {31'b0, ID_vld}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
